// File: rtl/memory_test_sequencer.sv
// memory_test_sequencer
// Runs the LFSR memory checker for a series of passes. Each pass gets a seed
// derived from the base seed, one start/done handshake, and a recorded result.
// Pass/fail counts, the first failing pass and an OR of per-DQ fail bits are
// accumulated. Every wait on the checker is bounded by TIMEOUT_CYCLES.
//
// Handshake with the checker: o_start is a level. It rises only after i_done
// has been seen low, and it stays high until i_done is seen high (or until a
// timeout or abort). After o_start falls, the sequencer waits for i_done to
// return low before it starts the next pass. A done level is therefore
// counted exactly once, even if the checker holds it.
module memory_test_sequencer #(
    parameter logic [15:0] NUM_PASSES     = 16'd4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50000000
) (
    input  logic         axi_clk,
    input  logic         rst,
    input  logic         i_run,
    input  logic         i_abort,
    input  logic         i_loop,
    input  logic [127:0] i_base_seed,
    input  logic [31:0]  i_check_mask,
    input  logic [31:0]  i_test_size,
    input  logic         i_lfsr_en,
    output logic         o_start,
    output logic [127:0] o_lfsr_seed,
    output logic [31:0]  o_check_mask,
    output logic [31:0]  o_test_size,
    output logic         o_lfsr_en,
    input  logic         i_done,
    input  logic         i_fail,
    input  logic [31:0]  i_dq_fail_expression,
    output logic         o_busy,
    output logic         o_complete,
    output logic         o_timeout,
    output logic         o_aborted,
    output logic [15:0]  o_pass_cnt,
    output logic [15:0]  o_fail_cnt,
    output logic [15:0]  o_first_fail_pass,
    output logic [31:0]  o_dq_fail_accum,
    output logic [2:0]   o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        RECORD    = 3'd4,
        RELEASE   = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t        state;
    logic [15:0]   pass_idx;
    logic [31:0]   timer;
    logic          loop_r;
    logic [127:0]  base_seed_r;
    logic [31:0]   mask_r;
    logic [31:0]   size_r;
    logic          lfsr_en_r;
    // Remembers an abort seen while the sequencer could not act on it yet.
    logic          abort_pend;

    logic          last_pass;
    logic          timer_exp;
    logic          abort_seen;

    assign last_pass  = !loop_r && (pass_idx == NUM_PASSES - 16'd1);
    assign timer_exp  = (timer == TIMEOUT_CYCLES - 32'd1);
    assign abort_seen = i_abort | abort_pend;
    assign o_busy     = (state != IDLE);
    assign o_state    = state;

    // Pass sequencing FSM with all checker-facing and status outputs registered.
    always_ff @(posedge axi_clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            pass_idx          <= 16'd0;
            timer             <= 32'd0;
            loop_r            <= 1'b0;
            base_seed_r       <= 128'd0;
            mask_r            <= 32'd0;
            size_r            <= 32'd0;
            lfsr_en_r         <= 1'b0;
            abort_pend        <= 1'b0;
            o_start           <= 1'b0;
            o_lfsr_seed       <= 128'd0;
            o_check_mask      <= 32'd0;
            o_test_size       <= 32'd0;
            o_lfsr_en         <= 1'b0;
            o_complete        <= 1'b0;
            o_timeout         <= 1'b0;
            o_aborted         <= 1'b0;
            o_pass_cnt        <= 16'd0;
            o_fail_cnt        <= 16'd0;
            o_first_fail_pass <= 16'hFFFF;
            o_dq_fail_accum   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_run) begin
                        loop_r            <= i_loop;
                        base_seed_r       <= i_base_seed;
                        mask_r            <= i_check_mask;
                        size_r            <= i_test_size;
                        lfsr_en_r         <= i_lfsr_en;
                        abort_pend        <= i_abort;
                        pass_idx          <= 16'd0;
                        o_complete        <= 1'b0;
                        o_timeout         <= 1'b0;
                        o_aborted         <= 1'b0;
                        o_pass_cnt        <= 16'd0;
                        o_fail_cnt        <= 16'd0;
                        o_first_fail_pass <= 16'hFFFF;
                        o_dq_fail_accum   <= 32'd0;
                        state             <= LOAD;
                    end
                end
                LOAD: begin
                    o_lfsr_seed  <= base_seed_r ^ {112'd0, pass_idx};
                    o_check_mask <= mask_r;
                    o_test_size  <= size_r;
                    o_lfsr_en    <= lfsr_en_r;
                    if (i_abort) abort_pend <= 1'b1;
                    state        <= START;
                end
                START: begin
                    o_start <= 1'b1;
                    timer   <= 32'd0;
                    if (i_abort) abort_pend <= 1'b1;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (i_done) begin
                        // Done wins over a simultaneous abort; the abort is kept for RELEASE.
                        if (i_abort) abort_pend <= 1'b1;
                        state <= RECORD;
                    end else if (timer_exp) begin
                        o_timeout <= 1'b1;
                        o_start   <= 1'b0;
                        timer     <= 32'd0;
                        state     <= RELEASE;
                    end else if (abort_seen) begin
                        o_aborted <= 1'b1;
                        o_start   <= 1'b0;
                        timer     <= 32'd0;
                        state     <= RELEASE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                RECORD: begin
                    if (o_pass_cnt != 16'hFFFF) o_pass_cnt <= o_pass_cnt + 16'd1;
                    if (i_fail) begin
                        if (o_fail_cnt != 16'hFFFF) o_fail_cnt <= o_fail_cnt + 16'd1;
                        o_dq_fail_accum <= o_dq_fail_accum | i_dq_fail_expression;
                        if (o_first_fail_pass == 16'hFFFF) o_first_fail_pass <= pass_idx;
                    end
                    if (i_abort) abort_pend <= 1'b1;
                    o_start <= 1'b0;
                    timer   <= 32'd0;
                    state   <= RELEASE;
                end
                RELEASE: begin
                    o_start <= 1'b0;
                    if (!i_done) begin
                        if (o_timeout || o_aborted || abort_seen || last_pass) begin
                            if (abort_seen) o_aborted <= 1'b1;
                            state <= FINISH;
                        end else begin
                            // 16-bit index wraps naturally in loop mode.
                            pass_idx <= pass_idx + 16'd1;
                            state    <= LOAD;
                        end
                    end else if (timer_exp) begin
                        o_timeout <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        if (i_abort) abort_pend <= 1'b1;
                        timer <= timer + 32'd1;
                    end
                end
                FINISH: begin
                    o_complete <= 1'b1;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    o_start <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_test_sequencer.sv
// Bench for memory_test_sequencer: a behavioural checker model answers each
// start with done after a set latency, and directed runs compare the status
// outputs against hand-computed values.
module tb_memory_test_sequencer;

    // ---------------- clock / reset ----------------
    logic         axi_clk = 1'b0;
    logic         rst;
    logic         i_run, i_abort, i_loop, i_lfsr_en;
    logic [127:0] i_base_seed;
    logic [31:0]  i_check_mask, i_test_size;
    logic         o_start;
    logic [127:0] o_lfsr_seed;
    logic [31:0]  o_check_mask, o_test_size;
    logic         o_lfsr_en;
    logic         i_done, i_fail;
    logic [31:0]  i_dq_fail_expression;
    logic         o_busy, o_complete, o_timeout, o_aborted;
    logic [15:0]  o_pass_cnt, o_fail_cnt, o_first_fail_pass;
    logic [31:0]  o_dq_fail_accum;
    logic [2:0]   o_state;

    always #5 axi_clk = ~axi_clk;

    // Timeout set above the model's 100-cycle done latency.
    memory_test_sequencer #(
        .NUM_PASSES    (16'd4),
        .TIMEOUT_CYCLES(32'd120)
    ) dut (
        .axi_clk             (axi_clk),
        .rst                 (rst),
        .i_run               (i_run),
        .i_abort             (i_abort),
        .i_loop              (i_loop),
        .i_base_seed         (i_base_seed),
        .i_check_mask        (i_check_mask),
        .i_test_size         (i_test_size),
        .i_lfsr_en           (i_lfsr_en),
        .o_start             (o_start),
        .o_lfsr_seed         (o_lfsr_seed),
        .o_check_mask        (o_check_mask),
        .o_test_size         (o_test_size),
        .o_lfsr_en           (o_lfsr_en),
        .i_done              (i_done),
        .i_fail              (i_fail),
        .i_dq_fail_expression(i_dq_fail_expression),
        .o_busy              (o_busy),
        .o_complete          (o_complete),
        .o_timeout           (o_timeout),
        .o_aborted           (o_aborted),
        .o_pass_cnt          (o_pass_cnt),
        .o_fail_cnt          (o_fail_cnt),
        .o_first_fail_pass   (o_first_fail_pass),
        .o_dq_fail_accum     (o_dq_fail_accum),
        .o_state             (o_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fails  = 0;
    logic [127:0] exp_q[$];
    logic [127:0] seen_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    task automatic check_seeds(input string tag);
        check({tag, "_nseed"}, 128'(seen_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_seed"}, (i < seen_q.size()) ? seen_q[i] : 128'd0, exp_q[i]);
        end
    endtask

    // ---------------- checker model ----------------
    int          m_lat = 100;
    int          m_hold = 0;
    int          m_never = 0;
    int          m_fail_pass = -1;
    logic [31:0] m_dq = 32'h0;
    int          m_cnt = 0;
    int          m_hold_cnt = 0;
    int          m_pass_no = 0;

    task automatic model_reset();
        m_cnt      = 0;
        m_hold_cnt = 0;
        m_pass_no  = 0;
        i_done     = 1'b0;
        i_fail     = 1'b0;
        i_dq_fail_expression = 32'h0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge axi_clk);
            if (!i_done) begin
                if (o_start && m_never == 0) begin
                    m_cnt++;
                    if (m_cnt >= m_lat) begin
                        i_done     = 1'b1;
                        i_fail     = (m_pass_no == m_fail_pass);
                        // Passing passes drive noise on the DQ bits; it must not be accumulated.
                        i_dq_fail_expression = i_fail ? m_dq : 32'hDEAD_0000;
                        m_cnt      = 0;
                        m_hold_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end else if (!o_start) begin
                if (m_hold_cnt >= m_hold) begin
                    i_done = 1'b0;
                    i_fail = 1'b0;
                    i_dq_fail_expression = 32'h0;
                    m_pass_no++;
                end else begin
                    m_hold_cnt++;
                end
            end
        end
    end

    // ---------------- start monitor ----------------
    logic start_prev = 1'b0;
    int   hi_len = 0;
    int   last_hi_len = 0;
    int   rises = 0;
    int   viol = 0;

    task automatic clear_mon();
        hi_len      = 0;
        last_hi_len = 0;
        rises       = 0;
        viol        = 0;
        seen_q.delete();
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(negedge axi_clk);
            if (o_start && !start_prev) begin
                rises++;
                seen_q.push_back(o_lfsr_seed);
                if (i_done) viol++;
            end
            if (o_start) hi_len++;
            else if (start_prev) begin
                last_hi_len = hi_len;
                hi_len = 0;
            end
            start_prev = o_start;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input string tag);
        @(negedge axi_clk);
        i_run = 1'b1;
        @(negedge axi_clk);
        i_run = 1'b0;
        check({tag, "_busy"}, 128'(o_busy), 128'd1);
        check({tag, "_cmpl_clr"}, 128'(o_complete), 128'd0);
    endtask

    task automatic wait_complete(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_complete && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        check({tag, "_complete"}, 128'(o_complete), 128'd1);
    endtask

    task automatic wait_pass_cnt(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (o_pass_cnt != target && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
    endtask

    localparam logic [127:0] BASE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        i_run = 1'b0; i_abort = 1'b0; i_loop = 1'b0; i_lfsr_en = 1'b0;
        i_base_seed = 128'd0; i_check_mask = 32'd0; i_test_size = 32'd0;
        repeat (3) @(negedge axi_clk);
        rst = 1'b0;
        @(negedge axi_clk);

        // reset state
        check("rst_start", 128'(o_start), 128'd0);
        check("rst_busy", 128'(o_busy), 128'd0);
        check("rst_pass", 128'(o_pass_cnt), 128'd0);
        check("rst_fail", 128'(o_fail_cnt), 128'd0);
        check("rst_first", 128'(o_first_fail_pass), 128'hFFFF);
        check("rst_accum", 128'(o_dq_fail_accum), 128'd0);
        check("rst_cmpl", 128'(o_complete), 128'd0);
        check("rst_seed", o_lfsr_seed, 128'd0);
        check("rst_state", 128'(o_state), 128'd0);

        // T1: four clean passes
        i_base_seed = BASE; i_check_mask = 32'hFFFF_0F0F; i_test_size = 32'h0000_4000; i_lfsr_en = 1'b1;
        model_reset(); clear_mon();
        exp_q.push_back(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        exp_q.push_back(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3211);
        exp_q.push_back(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3212);
        exp_q.push_back(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3213);
        start_run("t1");
        i_check_mask = 32'h0; i_test_size = 32'h0; i_lfsr_en = 1'b0;
        wait_complete("t1", 2000);
        check("t1_pass", 128'(o_pass_cnt), 128'd4);
        check("t1_fail", 128'(o_fail_cnt), 128'd0);
        check("t1_first", 128'(o_first_fail_pass), 128'hFFFF);
        check("t1_accum", 128'(o_dq_fail_accum), 128'd0);
        check("t1_tmo", 128'(o_timeout), 128'd0);
        check("t1_abort", 128'(o_aborted), 128'd0);
        check("t1_busy", 128'(o_busy), 128'd0);
        check("t1_start", 128'(o_start), 128'd0);
        check("t1_rises", 128'(rises), 128'd4);
        check("t1_mask", 128'(o_check_mask), 128'hFFFF_0F0F);
        check("t1_size", 128'(o_test_size), 128'h4000);
        check("t1_lfsr", 128'(o_lfsr_en), 128'd1);
        check_seeds("t1");

        // T2: pass 2 fails on DQ8
        m_fail_pass = 2; m_dq = 32'h0000_0100;
        model_reset(); clear_mon();
        start_run("t2");
        wait_complete("t2", 2000);
        check("t2_pass", 128'(o_pass_cnt), 128'd4);
        check("t2_fail", 128'(o_fail_cnt), 128'd1);
        check("t2_first", 128'(o_first_fail_pass), 128'd2);
        check("t2_accum", 128'(o_dq_fail_accum), 128'h100);
        m_fail_pass = -1;

        // T3: checker never answers
        m_never = 1;
        model_reset(); clear_mon();
        start_run("t3");
        wait_complete("t3", 1000);
        check("t3_hi_len", 128'(last_hi_len), 128'd120);
        check("t3_tmo", 128'(o_timeout), 128'd1);
        check("t3_abort", 128'(o_aborted), 128'd0);
        check("t3_pass", 128'(o_pass_cnt), 128'd0);
        check("t3_start", 128'(o_start), 128'd0);
        m_never = 0;

        // T4: abort while waiting for done
        model_reset(); clear_mon();
        start_run("t4");
        repeat (20) @(negedge axi_clk);
        i_abort = 1'b1;
        wait_complete("t4", 500);
        i_abort = 1'b0;
        check("t4_abort", 128'(o_aborted), 128'd1);
        check("t4_tmo", 128'(o_timeout), 128'd0);
        check("t4_pass", 128'(o_pass_cnt), 128'd0);
        check("t4_start", 128'(o_start), 128'd0);

        // T5: loop mode, abort after third done
        i_loop = 1'b1;
        model_reset(); clear_mon();
        start_run("t5");
        i_loop = 1'b0;
        wait_pass_cnt(16'd3, 1500);
        i_abort = 1'b1;
        wait_complete("t5", 500);
        i_abort = 1'b0;
        check("t5_abort", 128'(o_aborted), 128'd1);
        check("t5_pass", 128'(o_pass_cnt), 128'd3);
        check("t5_start", 128'(o_start), 128'd0);
        check("t5_busy", 128'(o_busy), 128'd0);
        check("t5_rises", 128'(rises), 128'd3);

        // T6: checker holds done 5 cycles after start falls
        m_hold = 5;
        model_reset(); clear_mon();
        start_run("t6");
        wait_complete("t6", 2000);
        check("t6_pass", 128'(o_pass_cnt), 128'd4);
        check("t6_rises", 128'(rises), 128'd4);
        check("t6_viol", 128'(viol), 128'd0);
        m_hold = 0;

        // T7: reset during WAIT_DONE of the second pass
        m_fail_pass = 0; m_dq = 32'h0000_0001;
        model_reset(); clear_mon();
        start_run("t7");
        wait_pass_cnt(16'd1, 500);
        repeat (20) @(negedge axi_clk);
        check("t7_pre_fail", 128'(o_fail_cnt), 128'd1);
        check("t7_pre_start", 128'(o_start), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_start", 128'(o_start), 128'd0);
        check("t7_busy", 128'(o_busy), 128'd0);
        check("t7_pass", 128'(o_pass_cnt), 128'd0);
        check("t7_fail", 128'(o_fail_cnt), 128'd0);
        check("t7_first", 128'(o_first_fail_pass), 128'hFFFF);
        check("t7_accum", 128'(o_dq_fail_accum), 128'd0);
        @(negedge axi_clk);
        rst = 1'b0;
        m_fail_pass = -1;
        model_reset();
        repeat (3) @(negedge axi_clk);
        check("t7_idle", 128'(o_state), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
